// File: rtl/gray_sched_pkg.sv
// Shared types and constants for the Gray conversion scheduler.
package gray_sched_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam int unsigned DataW         = 16;
  localparam int unsigned DefaultNumReq = 4;

endpackage

// File: rtl/bin2gray16.sv
// 16-bit binary-to-Gray converter; output is driven to zero while disabled.
module bin2gray16 (
  input  logic        en,
  input  logic [15:0] bin,
  output logic [15:0] gray
);

  always_comb begin
    gray = en ? (bin ^ (bin >> 1)) : 16'h0000;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[(32'(ptr) + k) % NUM_REQ]) begin
        valid = 1'b1;
        idx   = IDX_W'((32'(ptr) + k) % NUM_REQ);
        grant[(32'(ptr) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_conversion_scheduler.sv
// Shares one binary-to-Gray converter among NUM_REQ requesters in round-robin order.
module gray_conversion_scheduler
  import gray_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DefaultNumReq,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     Clock_In,
  input  logic                     Reset_n_In,
  input  logic                     Enable_In,
  input  logic [NUM_REQ-1:0]       Req_In,
  input  logic [DataW*NUM_REQ-1:0] Binary_Data_In,
  output logic [NUM_REQ-1:0]       Grant_Out,
  output logic [IDX_W-1:0]         Grant_Idx_Out,
  output logic [NUM_REQ-1:0]       Done_Out,
  output logic [DataW-1:0]         Gray_Data_Out,
  output logic                     Busy_Out,
  output logic [15:0]              Conversion_Count_Out
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, ptr_q, ptr_next, arb_idx;
  logic [NUM_REQ-1:0]   grant_q, arb_grant;
  logic                 arb_valid, take, conv_en;
  logic [DataW-1:0]     data_q, gray_q, conv_gray;
  logic [15:0]          count_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (Req_In),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  bin2gray16 u_conv (
    .en   (conv_en),
    .bin  (data_q),
    .gray (conv_gray)
  );

  assign ptr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    conv_en = 1'b0;
    take    = 1'b0;
    case (state_q)
      StIdle: begin
        if (Enable_In && arb_valid) begin
          take    = 1'b1;
          state_d = StConvert;
        end
      end
      StConvert: begin
        conv_en = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;  // illegal encoding recovers to idle
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      gray_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        idx_q   <= arb_idx;
        grant_q <= arb_grant;
        data_q  <= Binary_Data_In[DataW*arb_idx +: DataW];
      end
      // Result and count update on entry to DONE so both are valid with the pulse.
      if (state_q == StConvert) begin
        gray_q  <= conv_gray;
        count_q <= count_q + 16'd1;
      end
      if (state_q == StDone) begin
        ptr_q <= ptr_next;
      end
    end
  end

  always_comb begin
    Busy_Out             = (state_q == StConvert) || (state_q == StDone);
    Grant_Out            = Busy_Out ? grant_q : '0;
    Done_Out             = (state_q == StDone) ? grant_q : '0;
    Grant_Idx_Out        = idx_q;
    Gray_Data_Out        = gray_q;
    Conversion_Count_Out = count_q;
  end

endmodule

// File: tb/tb_gray_conversion_scheduler.sv
// Self-checking bench for gray_conversion_scheduler against a transaction-level model.
module tb_gray_conversion_scheduler;

  logic        Clock_In = 1'b0;
  logic        Reset_n_In;
  logic        Enable_In;
  logic [3:0]  Req_In;
  logic [63:0] Binary_Data_In;
  logic [3:0]  Grant_Out;
  logic [1:0]  Grant_Idx_Out;
  logic [3:0]  Done_Out;
  logic [15:0] Gray_Data_Out;
  logic        Busy_Out;
  logic [15:0] Conversion_Count_Out;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr;
  logic [15:0] m_count;

  gray_conversion_scheduler #(
    .NUM_REQ (4)
  ) dut (
    .Clock_In             (Clock_In),
    .Reset_n_In           (Reset_n_In),
    .Enable_In            (Enable_In),
    .Req_In               (Req_In),
    .Binary_Data_In       (Binary_Data_In),
    .Grant_Out            (Grant_Out),
    .Grant_Idx_Out        (Grant_Idx_Out),
    .Done_Out             (Done_Out),
    .Gray_Data_Out        (Gray_Data_Out),
    .Busy_Out             (Busy_Out),
    .Conversion_Count_Out (Conversion_Count_Out)
  );

  always #5 Clock_In = ~Clock_In;

  function automatic logic [15:0] model_gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  // Rotate the request vector so the pointer sits at bit 0, then take the lowest set bit.
  function automatic int model_pick(input logic [3:0] req, input int ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {req, req};
    rot = 4'(dbl >> ptr);
    for (int j = 0; j < 4; j++) if (rot[j]) return (ptr + j) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    Reset_n_In     = 1'b0;
    Enable_In      = 1'b1;
    Req_In         = 4'h0;
    Binary_Data_In = 64'h0;
    repeat (2) @(negedge Clock_In);
    Reset_n_In = 1'b1;
    m_ptr      = 0;
    m_count    = 16'h0000;
  endtask

  // One full transaction from an IDLE cycle; w returns the served requester.
  task automatic txn(input logic [3:0] req, input logic [63:0] data, input bit drop_en,
                     output int w);
    logic [3:0]  eg;
    logic [15:0] d;
    Req_In         = req;
    Binary_Data_In = data;
    w  = model_pick(req, m_ptr);
    eg = 4'b0001 << w;
    d  = data[16*w +: 16];
    @(negedge Clock_In);
    checks++;
    if (Grant_Out !== eg || Busy_Out !== 1'b1 || Done_Out !== 4'h0) begin
      errors++;
      $display("FAIL convert_grant: grant=%b busy=%b done=%b, expected grant=%b busy=1 done=0",
               Grant_Out, Busy_Out, Done_Out, eg);
    end
    checks++;
    if (Grant_Idx_Out !== 2'(w)) begin
      errors++;
      $display("FAIL grant_idx: got %0d expected %0d", Grant_Idx_Out, w);
    end
    // Post-grant changes must not affect the latched conversion.
    Binary_Data_In = {$urandom, $urandom};
    Req_In[w]      = 1'b0;
    if (drop_en) Enable_In = 1'b0;
    @(negedge Clock_In);
    m_count = m_count + 16'd1;
    checks++;
    if (Done_Out !== eg || Gray_Data_Out !== model_gray(d) || Busy_Out !== 1'b1) begin
      errors++;
      $display("FAIL done_result: done=%b gray=%h busy=%b, expected done=%b gray=%h busy=1",
               Done_Out, Gray_Data_Out, Busy_Out, eg, model_gray(d));
    end
    checks++;
    if (Conversion_Count_Out !== m_count) begin
      errors++;
      $display("FAIL count: got %h expected %h", Conversion_Count_Out, m_count);
    end
    @(negedge Clock_In);
    checks++;
    if (Done_Out !== 4'h0 || Busy_Out !== 1'b0 || Gray_Data_Out !== model_gray(d)) begin
      errors++;
      $display("FAIL back_idle: done=%b busy=%b gray=%h, expected done=0 busy=0 gray=%h",
               Done_Out, Busy_Out, Gray_Data_Out, model_gray(d));
    end
    m_ptr = (w + 1) % 4;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Grant_Out, Grant_Idx_Out, Done_Out, Gray_Data_Out, Busy_Out, Conversion_Count_Out}
        !== '0) begin
      errors++;
      $display("FAIL reset_state: grant=%b idx=%0d done=%b gray=%h busy=%b count=%h, expected 0",
               Grant_Out, Grant_Idx_Out, Done_Out, Gray_Data_Out, Busy_Out,
               Conversion_Count_Out);
    end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    txn(4'b0001, 64'h0000_0000_0000_00FF, 1'b0, w);
    checks++;
    if (Gray_Data_Out !== 16'h0080 || Conversion_Count_Out !== 16'd1) begin
      errors++;
      $display("FAIL single: gray=%h count=%h, expected gray=0080 count=0001",
               Gray_Data_Out, Conversion_Count_Out);
    end
  endtask

  task automatic test_back_to_back();
    int          w;
    logic [63:0] data;
    logic [15:0] exp_g [4];
    exp_g = '{16'h0000, 16'h8000, 16'h1B2E, 16'h0001};
    data  = {16'h0001, 16'h1234, 16'hFFFF, 16'h0000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      // Requesters already served drop out; the rest keep requesting.
      txn(4'b1111 << i, data, 1'b0, w);
      checks++;
      if (w !== i || Gray_Data_Out !== exp_g[i]) begin
        errors++;
        $display("FAIL b2b_order: served=%0d gray=%h, expected served=%0d gray=%h",
                 w, Gray_Data_Out, i, exp_g[i]);
      end
    end
    checks++;
    if (Conversion_Count_Out !== 16'd4) begin
      errors++;
      $display("FAIL b2b_count: got %h expected 0004", Conversion_Count_Out);
    end
  endtask

  task automatic test_fairness();
    int w;
    int order [3];
    do_reset();
    txn(4'b0101, {$urandom, $urandom}, 1'b0, order[0]);
    txn(4'b0101, {$urandom, $urandom}, 1'b0, order[1]);
    txn(4'b0001, {$urandom, $urandom}, 1'b0, order[2]);
    w = order[1];
    checks++;
    if (order[0] !== 0 || w !== 2 || order[2] !== 0) begin
      errors++;
      $display("FAIL fairness: order=%0d,%0d,%0d expected 0,2,0", order[0], w, order[2]);
    end
  endtask

  task automatic test_enable();
    int w;
    do_reset();
    Enable_In      = 1'b0;
    Req_In         = 4'b1111;
    Binary_Data_In = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock_In);
      checks++;
      if (Busy_Out !== 1'b0 || Grant_Out !== 4'h0 || Done_Out !== 4'h0) begin
        errors++;
        $display("FAIL enable_low: busy=%b grant=%b done=%b, expected all 0",
                 Busy_Out, Grant_Out, Done_Out);
      end
    end
    Enable_In = 1'b1;
    txn(4'b1010, {$urandom, $urandom}, 1'b1, w);
    Enable_In = 1'b1;
    txn(4'b1010, {$urandom, $urandom}, 1'b0, w);
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    txn(4'b0001, {$urandom, $urandom}, 1'b0, w);
    Req_In         = 4'b1001;
    Binary_Data_In = {$urandom, $urandom};
    @(negedge Clock_In);
    Reset_n_In = 1'b0;
    #1;
    checks++;
    if ({Grant_Out, Grant_Idx_Out, Done_Out, Gray_Data_Out, Busy_Out, Conversion_Count_Out}
        !== '0) begin
      errors++;
      $display("FAIL reset_mid: grant=%b idx=%0d done=%b gray=%h busy=%b count=%h, expected 0",
               Grant_Out, Grant_Idx_Out, Done_Out, Gray_Data_Out, Busy_Out,
               Conversion_Count_Out);
    end
    @(negedge Clock_In);
    checks++;
    if (Done_Out !== 4'h0) begin
      errors++;
      $display("FAIL reset_no_done: got %b expected 0000", Done_Out);
    end
    Reset_n_In = 1'b1;
    m_ptr      = 0;
    m_count    = 16'h0000;
    txn(4'b1001, {$urandom, $urandom}, 1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL reset_ptr: served=%0d expected 0", w);
    end
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    force dut.count_q = 16'hFFFF;
    @(negedge Clock_In);
    release dut.count_q;
    m_count = 16'hFFFF;
    txn(4'b0100, {$urandom, $urandom}, 1'b0, w);
    checks++;
    if (Conversion_Count_Out !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: got %h expected 0000", Conversion_Count_Out);
    end
  endtask

  task automatic test_random();
    int w;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      txn(4'($urandom_range(1, 15)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), w);
      Enable_In = 1'b1;
    end
  endtask

  initial begin
    Reset_n_In     = 1'b0;
    Enable_In      = 1'b0;
    Req_In         = 4'h0;
    Binary_Data_In = 64'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_enable();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
